// File: rtl/xbar_pkg.sv
// Shared constants for the packet crossbar: ctl word field layout and default sizes.
package xbar_pkg;

   localparam int DEF_NUM_QUEUES = 12;
   localparam int DEF_DATA_WIDTH = 480;
   localparam int DEF_CTL_WIDTH  = 32;

   localparam int CTL_DEST_LSB = 0;
   localparam int CTL_DEST_W   = 4;
   localparam int CTL_SOP_BIT  = 4;
   localparam int CTL_EOP_BIT  = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or above ptr, wrapping.
module rr_pick #(
   parameter int N  = 12,
   parameter int IW = 4
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/xbar_output_arbiter.sv
// Per-output packet scheduler: round-robin sop arbitration, whole-packet grant hold,
// registered word output and mid-packet stall abort.
module xbar_output_arbiter
   import xbar_pkg::*;
#(
   parameter int NUM_QUEUES = DEF_NUM_QUEUES,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CTL_WIDTH  = DEF_CTL_WIDTH,
   parameter int OUT_PORT   = 0,
   parameter int TIMEOUT    = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_QUEUES-1:0]            in_valid,
   input  logic [NUM_QUEUES*CTL_WIDTH-1:0]  in_ctl,
   input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
   output logic [NUM_QUEUES-1:0]            in_ready,
   output logic                             out_wr,
   output logic [CTL_WIDTH-1:0]             out_ctl,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [3:0]                       out_grant_id,
   output logic                             out_busy,
   output logic                             out_abort
);

   localparam int IW = 4;
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
      nxt = (i == IW'(NUM_QUEUES - 1)) ? '0 : i + IW'(1);
   endfunction

   arb_state_e state_q, state_d;
   logic [IW-1:0]         ptr_q, ptr_d, owner_q, owner_d, gid_q, gid_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  wr_q, wr_d, busy_q, busy_d, abort_q, abort_d;
   logic [CTL_WIDTH-1:0]  ctl_q, ctl_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   logic [CTL_WIDTH-1:0]  ctl_arr  [NUM_QUEUES];
   logic [DATA_WIDTH-1:0] data_arr [NUM_QUEUES];
   logic [NUM_QUEUES-1:0] elig, pick_gnt;
   logic [IW-1:0]         pick_idx, sel;
   logic                  pick_any, accept;
   logic [CTL_WIDTH-1:0]  sel_ctl;
   logic [DATA_WIDTH-1:0] sel_data;

   for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_unpack
      assign ctl_arr[g]  = in_ctl[g*CTL_WIDTH +: CTL_WIDTH];
      assign data_arr[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
      assign elig[g]     = in_valid[g] && ctl_arr[g][CTL_SOP_BIT] &&
                           (ctl_arr[g][CTL_DEST_LSB +: CTL_DEST_W] == CTL_DEST_W'(OUT_PORT));
   end

   rr_pick #(.N(NUM_QUEUES), .IW(IW)) u_pick (
      .req (elig),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Once a packet owns the output, only the owner's valid matters; sop/dest are ignored.
   assign sel      = (state_q == ST_IDLE) ? pick_idx : owner_q;
   assign accept   = (state_q == ST_IDLE) ? pick_any : in_valid[owner_q];
   assign sel_ctl  = ctl_arr[sel];
   assign sel_data = data_arr[sel];

   always_comb begin
      in_ready = '0;
      if (rst) begin
         if (state_q == ST_IDLE) in_ready = pick_gnt;
         else                    in_ready[owner_q] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      tmo_d   = tmo_q;
      gid_d   = gid_q;
      busy_d  = busy_q;
      ctl_d   = ctl_q;
      data_d  = data_q;
      wr_d    = 1'b0;
      abort_d = 1'b0;
      if (accept) begin
         wr_d   = 1'b1;
         ctl_d  = sel_ctl;
         data_d = sel_data;
         tmo_d  = '0;
      end
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               gid_d = pick_idx;
               if (sel_ctl[CTL_EOP_BIT]) begin
                  ptr_d = nxt(pick_idx);
               end else begin
                  state_d = ST_BUSY;
                  owner_d = pick_idx;
                  busy_d  = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            if (accept) begin
               if (sel_ctl[CTL_EOP_BIT]) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  ptr_d   = nxt(owner_q);
               end
            end else if (tmo_q == TMO_LAST) begin
               // This idle cycle brings the stall count to TIMEOUT-1: abandon the packet.
               abort_d = 1'b1;
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               ptr_d   = nxt(owner_q);
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         tmo_q   <= '0;
         gid_q   <= '0;
         busy_q  <= 1'b0;
         wr_q    <= 1'b0;
         abort_q <= 1'b0;
         ctl_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         tmo_q   <= tmo_d;
         gid_q   <= gid_d;
         busy_q  <= busy_d;
         wr_q    <= wr_d;
         abort_q <= abort_d;
         ctl_q   <= ctl_d;
         data_q  <= data_d;
      end
   end

   assign out_wr       = wr_q;
   assign out_ctl      = ctl_q;
   assign out_data     = data_q;
   assign out_grant_id = gid_q;
   assign out_busy     = busy_q;
   assign out_abort    = abort_q;

endmodule

// File: tb/tb_xbar_output_arbiter.sv
// Scoreboard bench for xbar_output_arbiter: per-input packet sources, in-order expected word queue.
module tb_xbar_output_arbiter;

   localparam int NQ = 12;
   localparam int DW = 480;
   localparam int CW = 32;

   typedef struct packed {
      logic [CW-1:0] ctl;
      logic [DW-1:0] data;
   } word_t;

   logic             clk, rst;
   logic [NQ-1:0]    in_valid, in_ready;
   logic [NQ*CW-1:0] in_ctl;
   logic [NQ*DW-1:0] in_data;
   logic             out_wr, out_busy, out_abort;
   logic [CW-1:0]    out_ctl;
   logic [DW-1:0]    out_data;
   logic [3:0]       out_grant_id;

   xbar_output_arbiter #(
      .NUM_QUEUES(NQ), .DATA_WIDTH(DW), .CTL_WIDTH(CW), .OUT_PORT(0), .TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctl(in_ctl), .in_data(in_data),
      .in_ready(in_ready), .out_wr(out_wr), .out_ctl(out_ctl), .out_data(out_data),
      .out_grant_id(out_grant_id), .out_busy(out_busy), .out_abort(out_abort)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   word_t    src [NQ][$];
   word_t    exp_q [$];
   int       xf_id_q [$], xf_cyc_q [$], wr_cyc_q [$], ab_cyc_q [$];
   logic     busy_log [$];
   logic [3:0] gid_log [$];
   logic [NQ-1:0] xfer;
   bit       multi_rdy;
   int       cyc, checks, errors;

   function automatic word_t mk(input int port, input int dest, input bit sop, input bit eop, input int seq);
      word_t w;
      w.ctl       = '0;
      w.ctl[3:0]  = 4'(dest);
      w.ctl[4]    = sop;
      w.ctl[5]    = eop;
      w.ctl[31:6] = 26'((port << 8) | seq);
      for (int k = 0; k < DW / 32; k++) w.data[k*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic push_pkt(input int port, input int len, input int dest, input bit to_exp);
      word_t w;
      for (int s = 0; s < len; s++) begin
         w = mk(port, dest, s == 0, s == len - 1, s);
         src[port].push_back(w);
         if (to_exp) exp_q.push_back(w);
      end
   endtask

   task automatic clr_logs();
      xf_id_q.delete(); xf_cyc_q.delete(); wr_cyc_q.delete(); ab_cyc_q.delete();
      busy_log.delete(); gid_log.delete(); multi_rdy = 0;
   endtask

   // Sources present their head word; a word leaves once the handshake seen at negedge has clocked.
   task automatic drive_loop();
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (rst)
            for (int i = 0; i < NQ; i++)
               if (xfer[i] && src[i].size() > 0) void'(src[i].pop_front());
         for (int i = 0; i < NQ; i++) begin
            in_valid[i]         = src[i].size() > 0;
            in_ctl[i*CW +: CW]  = (src[i].size() > 0) ? src[i][0].ctl  : '0;
            in_data[i*DW +: DW] = (src[i].size() > 0) ? src[i][0].data : '0;
         end
      end
   endtask

   task automatic mon_loop();
      word_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            xfer = in_valid & in_ready;
            if ($countones(in_ready) > 1) multi_rdy = 1;
            for (int i = 0; i < NQ; i++)
               if (xfer[i]) begin xf_id_q.push_back(i); xf_cyc_q.push_back(cyc); end
            if (out_abort) ab_cyc_q.push_back(cyc);
            if (out_wr) begin
               wr_cyc_q.push_back(cyc);
               busy_log.push_back(out_busy);
               gid_log.push_back(out_grant_id);
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_spurious: out_wr with ctl=%h, expected no word", out_ctl);
               end else begin
                  e = exp_q.pop_front();
                  if (out_ctl !== e.ctl || out_data !== e.data) begin
                     errors++;
                     $display("FAIL sb_word: got ctl=%h data=%h.., expected ctl=%h data=%h..",
                              out_ctl, out_data[31:0], e.ctl, e.data[31:0]);
                  end
               end
            end
         end else begin
            xfer = '0;
         end
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      bit empty;
      ok = 0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk); #1;
         empty = (exp_q.size() == 0);
         for (int i = 0; i < NQ; i++) if (src[i].size() != 0) empty = 0;
         if (empty) begin ok = 1; break; end
      end
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      push_pkt(4, 1, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({out_wr, out_busy, out_abort, out_grant_id} !== 7'd0 || out_ctl !== '0 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got wr=%b busy=%b abort=%b gid=%0d ctl=%h, expected all 0",
                  out_wr, out_busy, out_abort, out_grant_id, out_ctl);
      end
      checks++;
      if (in_ready !== '0) begin
         errors++;
         $display("FAIL reset_ready: got in_ready=%h with eligible sop present, expected 0", in_ready);
      end
      src[4].delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      clr_logs();
   endtask

   task automatic test_single_packet();
      bit ok;
      clr_logs();
      push_pkt(3, 4, 0, 1);
      wait_idle(60, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL t1_drain: got timeout, expected packet drained"); end
      checks++;
      if (wr_cyc_q.size() != 4 || xf_cyc_q.size() < 1) begin
         errors++;
         $display("FAIL t1_count: got %0d words, expected 4", wr_cyc_q.size());
      end else begin
         checks++;
         if (wr_cyc_q[0] != xf_cyc_q[0] + 1 || wr_cyc_q[3] != wr_cyc_q[0] + 3) begin
            errors++;
            $display("FAIL t1_latency: got first wr cyc %0d last %0d, sop xfer cyc %0d, expected %0d..%0d",
                     wr_cyc_q[0], wr_cyc_q[3], xf_cyc_q[0], xf_cyc_q[0] + 1, xf_cyc_q[0] + 4);
         end
         checks++;
         if ({busy_log[0], busy_log[1], busy_log[2], busy_log[3]} !== 4'b1110 ||
             gid_log[0] !== 4'd3 || gid_log[3] !== 4'd3) begin
            errors++;
            $display("FAIL t1_busy_gid: got busy=%b%b%b%b gid=%0d, expected busy=1110 gid=3",
                     busy_log[0], busy_log[1], busy_log[2], busy_log[3], gid_log[0]);
         end
      end
      checks++;
      if (out_busy !== 1'b0) begin errors++; $display("FAIL t1_busy_end: got %b, expected 0", out_busy); end
   endtask

   task automatic test_rr_order();
      bit ok, bad;
      int exp_ids [9] = '{5, 5, 9, 9, 9, 9, 2, 2, 2};
      clr_logs();
      push_pkt(5, 2, 0, 1);
      push_pkt(9, 4, 0, 1);
      push_pkt(2, 3, 0, 1);
      wait_idle(80, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL t2_drain: got timeout, expected 3 packets drained"); end
      bad = (xf_id_q.size() != 9);
      if (!bad) for (int k = 0; k < 9; k++) if (xf_id_q[k] != exp_ids[k]) bad = 1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL t2_grant_order: got %0d transfers first id %0d, expected order 5,5,9,9,9,9,2,2,2",
                  xf_id_q.size(), (xf_id_q.size() > 0) ? xf_id_q[0] : -1);
      end
      checks++;
      if (multi_rdy || wr_cyc_q.size() != 9 || wr_cyc_q[8] != wr_cyc_q[0] + 8) begin
         errors++;
         $display("FAIL t2_back_to_back: got multi_ready=%0d words=%0d, expected 0 and 9 contiguous",
                  multi_rdy, wr_cyc_q.size());
      end
   endtask

   task automatic test_wrap();
      bit ok;
      clr_logs();
      push_pkt(11, 1, 0, 1);
      push_pkt(0, 2, 0, 1);
      wait_idle(40, ok);
      checks++;
      if (!ok || xf_id_q.size() != 3) begin
         errors++;
         $display("FAIL t3_drain: got ok=%0d transfers=%0d, expected 1 and 3", ok, xf_id_q.size());
      end else begin
         checks++;
         if (xf_id_q[0] != 11 || xf_id_q[1] != 0 || xf_cyc_q[1] != xf_cyc_q[0] + 1) begin
            errors++;
            $display("FAIL t3_wrap: got ids %0d,%0d cycles %0d,%0d, expected 11 then 0 adjacent",
                     xf_id_q[0], xf_id_q[1], xf_cyc_q[0], xf_cyc_q[1]);
         end
      end
      checks++;
      if (out_grant_id !== 4'd0) begin errors++; $display("FAIL t3_gid: got %0d, expected 0", out_grant_id); end
   endtask

   task automatic test_wrong_dest();
      clr_logs();
      push_pkt(7, 1, 5, 0);
      repeat (30) @(negedge clk);
      #1;
      checks++;
      if (wr_cyc_q.size() != 0 || xf_id_q.size() != 0 || src[7].size() != 1) begin
         errors++;
         $display("FAIL t4_wrong_dest: got words=%0d transfers=%0d, expected 0 and 0",
                  wr_cyc_q.size(), xf_id_q.size());
      end
      src[7].delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout();
      bit ok;
      clr_logs();
      src[1].push_back(mk(1, 0, 1, 0, 0));
      exp_q.push_back(src[1][0]);
      push_pkt(2, 2, 0, 1);
      wait_idle(200, ok);
      checks++;
      if (!ok || ab_cyc_q.size() != 1 || xf_id_q.size() != 3) begin
         errors++;
         $display("FAIL t5_abort_count: got ok=%0d aborts=%0d transfers=%0d, expected 1,1,3",
                  ok, ab_cyc_q.size(), xf_id_q.size());
      end else begin
         checks++;
         if (xf_id_q[0] != 1 || ab_cyc_q[0] != xf_cyc_q[0] + 64) begin
            errors++;
            $display("FAIL t5_abort_time: got abort cyc %0d, expected %0d", ab_cyc_q[0], xf_cyc_q[0] + 64);
         end
         checks++;
         if (xf_id_q[1] != 2 || xf_cyc_q[1] != ab_cyc_q[0]) begin
            errors++;
            $display("FAIL t5_next_grant: got id %0d at cyc %0d, expected 2 at %0d",
                     xf_id_q[1], xf_cyc_q[1], ab_cyc_q[0]);
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      bit ok;
      int n;
      clr_logs();
      for (int s = 0; s < 5; s++) begin
         src[0].push_back(mk(0, 0, s == 0, s == 4, s));
         if (s < 2) exp_q.push_back(src[0][s]);
      end
      for (n = 0; n < 40; n++) begin
         @(negedge clk); #1;
         if (xf_id_q.size() >= 2) break;
      end
      checks++;
      if (n >= 40) begin errors++; $display("FAIL t6_start: got timeout, expected two words accepted"); end
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({out_wr, out_busy, out_abort, out_grant_id} !== 7'd0 || out_ctl !== '0 ||
          out_data !== '0 || in_ready !== '0) begin
         errors++;
         $display("FAIL t6_async_reset: got wr=%b busy=%b abort=%b gid=%0d rdy=%h, expected all 0",
                  out_wr, out_busy, out_abort, out_grant_id, in_ready);
      end
      checks++;
      if (exp_q.size() != 0 || ab_cyc_q.size() != 0) begin
         errors++;
         $display("FAIL t6_pre_reset: got pending=%0d aborts=%0d, expected 0 and 0",
                  exp_q.size(), ab_cyc_q.size());
      end
      src[0].delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      clr_logs();
      push_pkt(0, 2, 0, 1);
      wait_idle(40, ok);
      checks++;
      if (!ok || xf_id_q.size() != 2 || xf_id_q[0] != 0 || ab_cyc_q.size() != 0) begin
         errors++;
         $display("FAIL t6_restart: got ok=%0d transfers=%0d aborts=%0d, expected 1,2,0",
                  ok, xf_id_q.size(), ab_cyc_q.size());
      end
   endtask

   initial begin
      rst = 1'b0;
      checks = 0;
      errors = 0;
      cyc = 0;
      xfer = '0;
      multi_rdy = 0;
      fork
         drive_loop();
         mon_loop();
      join_none
      test_reset();
      test_single_packet();
      test_rr_order();
      test_wrap();
      test_wrong_dest();
      test_timeout();
      test_reset_mid_packet();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xbar_output_arbiter.md
Name: xbar_output_arbiter

Overview:
- Per-output scheduler for the 12x12 packet crossbar. One instance per crossbar output port.
- Takes 12 word-level request streams of 480-bit data and 32-bit ctl, as presented by the selector stage.
- Grants one requester at a time, round-robin, and holds the grant for the whole packet (sop to eop).
- Drives a registered output word stream into the lookup stage, and aborts a stalled packet after a timeout.

Parameters:
- NUM_QUEUES, 12, number of requesting input ports.
- DATA_WIDTH, 480, data word width.
- CTL_WIDTH, 32, ctl word width.
- OUT_PORT, 0, index of the output this instance serves; compared against the ctl destination field.
- TIMEOUT, 64, idle cycles allowed mid-packet before abort; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  NUM_QUEUES  per-input word valid.
- in_ctl  in  NUM_QUEUES*CTL_WIDTH  flattened ctl words; input i occupies bits [i*32 +: 32].
- in_data  in  NUM_QUEUES*DATA_WIDTH  flattened data words; input i occupies bits [i*480 +: 480].
- in_ready  out  NUM_QUEUES  per-input accept, combinational; a word transfers when valid and ready are both high.
- out_wr  out  1  registered output word valid.
- out_ctl  out  CTL_WIDTH  registered output ctl.
- out_data  out  DATA_WIDTH  registered output data.
- out_grant_id  out  4  index of the current owner, registered.
- out_busy  out  1  high while a packet owns the output.
- out_abort  out  1  one-cycle pulse when a packet is abandoned.

Behaviour:
- Ctl field layout:
  - ctl[3:0] = destination port.
  - ctl[4] = sop.
  - ctl[5] = eop.
  - ctl[31:6] = passthrough.
- Reset (rst low, asynchronous): state goes to IDLE; the RR pointer goes to 0; out_wr, out_ctl, out_data, out_grant_id, out_busy, out_abort, the timeout counter and in_ready all go to 0.
- A word is eligible for input i when in_valid[i]=1, sop=1 and dest==OUT_PORT.
- State IDLE:
  - The winner is the first eligible input scanning from ptr upward, modulo NUM_QUEUES.
  - in_ready[winner]=1 in the same cycle; all other in_ready bits are 0.
  - The accepted word appears on out_wr/out_ctl/out_data the next cycle (latency 1).
  - If the accepted word also has eop=1 (single-word packet): stay in IDLE and set ptr=winner+1.
  - Otherwise: go to BUSY, owner=winner, out_busy=1 from the next cycle.
- State BUSY:
  - in_ready[owner]=1; all other in_ready bits are 0.
  - Every valid word from owner is forwarded with latency 1, regardless of its sop or dest fields.
  - A word with eop=1 is forwarded, then state goes to IDLE and ptr=owner+1 (wrapping 11 to 0). The next arbitration can occur in the cycle right after the eop cycle.
  - Timeout counter:
    - Clears on each accepted word.
    - Increments on each cycle with in_valid[owner]=0.
    - When it reaches TIMEOUT-1: out_abort pulses for one cycle, state goes to IDLE, ptr=owner+1, and no word is emitted.
- out_wr=0 on every cycle with no accepted word. out_ctl and out_data hold their last value.
- Non-granted requesters must hold their word until ready. The block never drops an eligible word silently.
- A new sop from a non-owner while BUSY waits. A sop with dest!=OUT_PORT is never granted.
- A sop arriving from the owner mid-packet is forwarded as data; protocol violations are not policed.
- Reset asserted mid-packet aborts immediately with no out_abort pulse; the upstream must restart the packet.
- ptr arithmetic is modulo NUM_QUEUES, 4 bits wide.

Decomposition:
- Shared package xbar_pkg holds:
  - CTL_DEST_LSB=0, CTL_DEST_W=4, CTL_SOP_BIT=4, CTL_EOP_BIT=5.
  - Defaults NUM_QUEUES=12, DATA_WIDTH=480, CTL_WIDTH=32.
- Sub-module rr_pick: a combinational round-robin priority encoder.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, 4-bit index, any.
  - Reused by the input-side scheduler.
- The FSM, timeout counter and 12:1 output mux stay in the top module.

Test Plan:
1. Reset, then input 3 sends 4 words (sop on word 0, eop on word 3) to dest=OUT_PORT=0 -> out_wr high for 4 cycles starting 1 cycle after the sop; out_grant_id=3; out_busy drops after eop; ptr=4.
2. Inputs 2, 5 and 9 all assert a sop in the same cycle with ptr=4 -> grant order 5, 9, 2, each packet complete with no interleaving; in_ready for the losers stays 0 until their turn.
3. Input 11 sends a single-word packet (sop and eop both set), then input 0 sends a sop in the next cycle -> both words are forwarded back-to-back; ptr wraps 11 to 0 and 0 is granted.
4. Input 7 sends a sop with dest=5 while OUT_PORT=0 -> in_ready[7] stays 0 and out_wr stays 0 indefinitely.
5. Input 1 sends a sop, then holds in_valid=0 for TIMEOUT cycles -> out_abort pulses exactly once after 63 idle cycles; state returns to IDLE; input 2, already waiting, is then granted.
6. Assert rst low during word 2 of a 5-word packet -> all outputs 0 asynchronously; after release, a fresh sop from input 0 is granted normally.
